// File: rtl/rvvi_depacketizer_pkg.sv
// Shared definitions for the RVVI receive path: core config, record sizing and FSM states.
package rvvi_depacketizer_pkg;

    typedef struct packed {
        int unsigned XLEN;
    } cvw_t;

    localparam cvw_t        CVW_DEFAULT    = '{XLEN: 64};
    localparam logic [15:0] RVVI_ETHERTYPE = 16'h005c;

    typedef enum logic [1:0] {HDR, PAY, DRAIN, HOLD} depack_state_t;

    function automatic int rvvi_width(input int xlen, input int max_csrs);
        return 72 + 5 * xlen + max_csrs * (xlen + 16);
    endfunction

endpackage

// File: rtl/rvvi_byte_assembler.sv
// Writes 2- or 4-byte chunks into an NBYTES record buffer at the running byte count.
// Bytes landing beyond the buffer are dropped; the count saturates instead of wrapping.
module rvvi_byte_assembler #(
    parameter int NBYTES = 79,
    parameter int CW     = $clog2(NBYTES + 4)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_clr,
    input  logic                i_load,
    input  logic                i_two,
    input  logic [31:0]         i_data,
    output logic [NBYTES*8-1:0] o_buf,
    output logic [CW-1:0]       o_count
);

    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    logic [CW-1:0] r_count;
    logic [7:0]    w_chunk [4];
    logic [2:0]    w_n;
    logic [CW:0]   w_sum;

    // A 2-byte chunk is the upper half of the word (payload bytes 0-1 after the ethertype).
    always_comb begin
        w_chunk[0] = i_two ? i_data[23:16] : i_data[7:0];
        w_chunk[1] = i_two ? i_data[31:24] : i_data[15:8];
        w_chunk[2] = i_data[23:16];
        w_chunk[3] = i_data[31:24];
        w_n        = i_two ? 3'd2 : 3'd4;
        w_sum      = {1'b0, r_count} + (CW+1)'(w_n);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= (w_sum > {1'b0, CNT_MAX}) ? CNT_MAX : w_sum[CW-1:0];
        end
    end

    assign o_count = r_count;

    generate
        for (genvar gi = 0; gi < NBYTES; gi++) begin : g_lane
            localparam logic [CW-1:0] LANE = CW'(gi);
            logic [CW-1:0] w_off;
            logic [7:0]    r_byte;

            assign w_off = LANE - r_count;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_byte <= '0;
                end else if (i_load && (LANE >= r_count) && (w_off < CW'(w_n))) begin
                    r_byte <= w_chunk[w_off[1:0]];
                end
            end

            assign o_buf[8*gi +: 8] = r_byte;
        end
    endgenerate

endmodule

// File: rtl/rvvi_depacketizer.sv
// Ethernet RX frame -> RVVI trace record with header/tkeep validation and valid/ready output.
// Optional frame statistics outputs are enabled by defining RVVI_DEPACK_STATS_EN.
module rvvi_depacketizer
    import rvvi_depacketizer_pkg::*;
#(
    parameter cvw_t        P         = CVW_DEFAULT,
    parameter int          MAX_CSRS  = 5,
    parameter logic [47:0] DST_MAC   = 48'h4502_1111_6843,
    parameter bit          CHECK_MAC = 1'b1,
    localparam int         RVVI_W    = rvvi_width(P.XLEN, MAX_CSRS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       RvviAxiRdata,
    input  logic [3:0]        RvviAxiRstrb,
    input  logic              RvviAxiRlast,
    input  logic              RvviAxiRvalid,
    output logic              RvviAxiRready,
    output logic [RVVI_W-1:0] rvvi,
    output logic              valid,
    input  logic              RvviReady,
`ifdef RVVI_DEPACK_STATS_EN
    output logic [31:0]       GoodFrames,
    output logic [31:0]       BadFrames,
`endif
    output logic              FrameErr
);

    localparam int RVVI_BYTES = (RVVI_W + 7) / 8;
    localparam int CW         = $clog2(RVVI_BYTES + 4);

    depack_state_t           r_state, w_state_next;
    logic [1:0]              r_beat, w_beat_next;
    logic                    r_err, w_err_next;
    logic                    r_frame_err, w_frame_err_next;
    logic                    w_beat, w_keep_bad, w_hdr_bad, w_reached;
    logic                    w_clr, w_load, w_two;
    logic [RVVI_BYTES*8-1:0] w_buf;
    logic [CW-1:0]           w_count;

    assign RvviAxiRready = (r_state != HOLD);
    assign valid         = (r_state == HOLD);
    assign FrameErr      = r_frame_err;
    assign rvvi          = w_buf[RVVI_W-1:0];
    assign w_beat        = RvviAxiRvalid & RvviAxiRready;
    assign w_keep_bad    = !RvviAxiRlast && (RvviAxiRstrb != 4'hF);
    assign w_reached     = ({1'b0, w_count} + (CW+1)'(4)) >= (CW+1)'(RVVI_BYTES);

    always_comb begin
        w_hdr_bad = 1'b0;
        case (r_beat)
            2'd0:    w_hdr_bad = CHECK_MAC && (RvviAxiRdata != DST_MAC[31:0]);
            2'd1:    w_hdr_bad = CHECK_MAC && (RvviAxiRdata[15:0] != DST_MAC[47:32]);
            2'd3:    w_hdr_bad = (RvviAxiRdata[15:0] != RVVI_ETHERTYPE);
            default: w_hdr_bad = 1'b0;
        endcase
    end

    always_comb begin
        w_state_next     = r_state;
        w_beat_next      = r_beat;
        w_err_next       = r_err;
        w_frame_err_next = 1'b0;
        w_clr            = 1'b0;
        w_load           = 1'b0;
        w_two            = 1'b0;
        case (r_state)
            HDR: begin
                w_clr = 1'b1;
                if (w_beat) begin
                    w_beat_next = r_beat + 2'd1;
                    if (RvviAxiRlast) begin
                        w_beat_next      = '0;
                        w_frame_err_next = 1'b1;
                    end else if (w_hdr_bad || w_keep_bad) begin
                        w_state_next = DRAIN;
                        w_err_next   = 1'b1;
                        w_beat_next  = '0;
                    end else if (r_beat == 2'd3) begin
                        w_state_next = PAY;
                        w_beat_next  = '0;
                        w_clr        = 1'b0;
                        w_load       = 1'b1;
                        w_two        = 1'b1;
                    end
                end
            end
            PAY: begin
                if (w_beat) begin
                    w_load = 1'b1;
                    if (RvviAxiRlast) begin
                        if (w_reached) begin
                            w_state_next = HOLD;
                        end else begin
                            w_state_next     = HDR;
                            w_frame_err_next = 1'b1;
                        end
                    end else if (w_keep_bad) begin
                        w_state_next = DRAIN;
                        w_err_next   = 1'b1;
                    end else if (w_reached) begin
                        w_state_next = DRAIN;
                        w_err_next   = 1'b0;
                    end
                end
            end
            DRAIN: begin
                if (w_beat) begin
                    if (RvviAxiRlast) begin
                        if (r_err) begin
                            w_state_next     = HDR;
                            w_frame_err_next = 1'b1;
                        end else begin
                            w_state_next = HOLD;
                        end
                    end else if (w_keep_bad) begin
                        w_err_next = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (RvviReady) begin
                    w_state_next = HDR;
                end
            end
            default: w_state_next = HDR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= HDR;
            r_beat      <= '0;
            r_err       <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_beat      <= w_beat_next;
            r_err       <= w_err_next;
            r_frame_err <= w_frame_err_next;
        end
    end

    rvvi_byte_assembler #(
        .NBYTES (RVVI_BYTES),
        .CW     (CW)
    ) u_assembler (
        .clk     (clk),
        .reset   (reset),
        .i_clr   (w_clr),
        .i_load  (w_load),
        .i_two   (w_two),
        .i_data  (RvviAxiRdata),
        .o_buf   (w_buf),
        .o_count (w_count)
    );

`ifdef RVVI_DEPACK_STATS_EN
    logic [31:0] r_good_frames, r_bad_frames;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_good_frames <= '0;
            r_bad_frames  <= '0;
        end else begin
            if ((w_state_next == HOLD) && (r_state != HOLD)) begin
                r_good_frames <= r_good_frames + 32'd1;
            end
            if (w_frame_err_next) begin
                r_bad_frames <= r_bad_frames + 32'd1;
            end
        end
    end

    assign GoodFrames = r_good_frames;
    assign BadFrames  = r_bad_frames;
`endif

endmodule

// File: tb/tb_rvvi_depacketizer.sv
// Directed + randomized frames for rvvi_depacketizer (XLEN=64, MAX_CSRS=3), checked against a byte-level frame model.
module tb_rvvi_depacketizer;
    import rvvi_depacketizer_pkg::*;

    localparam cvw_t        TB_P    = '{XLEN: 64};
    localparam int          TB_CSRS = 3;
    localparam logic [47:0] TB_DST  = 48'h4502_1111_6843;
    localparam int          RW      = 72 + 5 * 64 + TB_CSRS * (64 + 16);
    localparam int          RB      = (RW + 7) / 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   RvviAxiRdata;
    logic [3:0]    RvviAxiRstrb;
    logic          RvviAxiRlast;
    logic          RvviAxiRvalid;
    logic          RvviAxiRready;
    logic [RW-1:0] rvvi;
    logic          valid;
    logic          RvviReady;
    logic          FrameErr;
`ifdef RVVI_DEPACK_STATS_EN
    logic [31:0]   GoodFrames, BadFrames;
`endif

    int            n_cmp = 0;
    int            n_err = 0;
    int            err_pulses = 0;
    int            n_good_m = 0;
    int            n_bad_m = 0;
    logic [7:0]    frm [$];
    logic [3:0]    keep_q [$];
    logic [RW-1:0] exp_rec;

    rvvi_depacketizer #(
        .P         (TB_P),
        .MAX_CSRS  (TB_CSRS),
        .DST_MAC   (TB_DST),
        .CHECK_MAC (1'b1)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .RvviAxiRdata  (RvviAxiRdata),
        .RvviAxiRstrb  (RvviAxiRstrb),
        .RvviAxiRlast  (RvviAxiRlast),
        .RvviAxiRvalid (RvviAxiRvalid),
        .RvviAxiRready (RvviAxiRready),
        .rvvi          (rvvi),
        .valid         (valid),
        .RvviReady     (RvviReady),
`ifdef RVVI_DEPACK_STATS_EN
        .GoodFrames    (GoodFrames),
        .BadFrames     (BadFrames),
`endif
        .FrameErr      (FrameErr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (FrameErr === 1'b1) err_pulses++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rec(input string tag);
        n_cmp++;
        assert (rvvi === exp_rec) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, rvvi, exp_rec);
        end
    endtask

    // Frame as bytes: dst (LSB first), src, ethertype (low byte first), payload, pad to a word.
    task automatic build_frame(input logic [47:0] dst, input logic [15:0] et, input int npay,
                               input int bad_keep_beat, input int trunc_beats);
        frm.delete();
        keep_q.delete();
        for (int i = 0; i < 6; i++) frm.push_back(dst[8*i +: 8]);
        for (int i = 0; i < 6; i++) frm.push_back(8'($urandom));
        frm.push_back(et[7:0]);
        frm.push_back(et[15:8]);
        for (int i = 0; i < npay; i++) frm.push_back(8'($urandom));
        while (frm.size() % 4 != 0) frm.push_back(8'($urandom));
        if (trunc_beats > 0) begin
            while (frm.size() > 4 * trunc_beats) void'(frm.pop_back());
        end
        for (int b = 0; b < frm.size() / 4; b++) keep_q.push_back(4'hF);
        if (bad_keep_beat >= 0 && bad_keep_beat < keep_q.size()) keep_q[bad_keep_beat] = 4'h7;
        keep_q[keep_q.size() - 1] = 4'($urandom_range(1, 15));
    endtask

    function automatic bit model_good();
        logic [47:0] d;
        logic [15:0] et;
        int          nb;
        nb = keep_q.size();
        if (nb * 4 < 14 + RB) return 1'b0;
        for (int i = 0; i < 6; i++) d[8*i +: 8] = frm[i];
        et = {frm[13], frm[12]};
        if (d != TB_DST || et != 16'h005c) return 1'b0;
        for (int b = 0; b < nb - 1; b++) if (keep_q[b] != 4'hF) return 1'b0;
        return 1'b1;
    endfunction

    task automatic send_frame(input int rst_beat);
        int nb;
        nb = keep_q.size();
        for (int b = 0; b < nb; b++) begin
            while ($urandom_range(0, 3) == 0) begin
                RvviAxiRvalid = 1'b0;
                RvviAxiRdata  = $urandom;
                RvviAxiRlast  = 1'($urandom_range(0, 1));
                RvviAxiRstrb  = 4'($urandom);
                @(posedge clk); #1;
            end
            RvviAxiRdata  = {frm[4*b+3], frm[4*b+2], frm[4*b+1], frm[4*b]};
            RvviAxiRstrb  = keep_q[b];
            RvviAxiRlast  = (b == nb - 1);
            RvviAxiRvalid = 1'b1;
            reset         = (b == rst_beat);
            @(posedge clk); #1;
            reset = 1'b0;
        end
        RvviAxiRvalid = 1'b0;
        RvviAxiRlast  = 1'b0;
    endtask

    task automatic run_frame(input string tag, input int rst_beat, input int hold);
        bit good;
        int p0;
        good = (rst_beat < 0) && model_good();
        if (good) begin
            for (int k = 0; k < RB; k++) exp_rec[8*k +: 8] = frm[14 + k];
        end
        if (rst_beat >= 0) begin
            n_good_m = 0;
            n_bad_m  = 0;
        end
        if (good) n_good_m++; else n_bad_m++;
        p0 = err_pulses;
        send_frame(rst_beat);
        chk({tag, ".valid"}, 64'(valid), 64'(good));
        chk({tag, ".ferr"}, 64'(FrameErr), 64'(!good));
        if (good) begin
            chk_rec({tag, ".rvvi"});
            for (int c = 0; c < hold; c++) begin
                RvviAxiRvalid = 1'($urandom_range(0, 1));
                RvviAxiRdata  = $urandom;
                RvviAxiRlast  = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
                chk({tag, ".hold_rdy"}, 64'(RvviAxiRready), 64'(0));
                chk({tag, ".hold_valid"}, 64'(valid), 64'(1));
                chk_rec({tag, ".hold_rvvi"});
            end
            RvviAxiRvalid = 1'b0;
            RvviAxiRlast  = 1'b0;
            RvviReady     = 1'b1;
            @(posedge clk); #1;
            RvviReady = 1'b0;
            chk({tag, ".release"}, 64'(valid), 64'(0));
        end else begin
            @(posedge clk); #1;
            chk({tag, ".pulse_len"}, 64'(FrameErr), 64'(0));
            chk({tag, ".valid_low"}, 64'(valid), 64'(0));
        end
        chk({tag, ".pulses"}, 64'(err_pulses - p0), 64'(good ? 0 : 1));
        chk({tag, ".rdy"}, 64'(RvviAxiRready), 64'(1));
`ifdef RVVI_DEPACK_STATS_EN
        chk({tag, ".good_cnt"}, 64'(GoodFrames), 64'(n_good_m));
        chk({tag, ".bad_cnt"}, 64'(BadFrames), 64'(n_bad_m));
`endif
        $display("frame %-8s beats=%0d expect_good=%0d compared=%0d", tag, keep_q.size(), good, n_cmp);
    endtask

    initial begin
        logic [47:0] d;
        logic [15:0] et;
        int          np, kb;

        reset         = 1'b1;
        RvviAxiRdata  = '0;
        RvviAxiRstrb  = 4'hF;
        RvviAxiRlast  = 1'b0;
        RvviAxiRvalid = 1'b0;
        RvviReady     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_rec = '0;
        chk("reset.valid", 64'(valid), 64'(0));
        chk("reset.ferr", 64'(FrameErr), 64'(0));
        chk("reset.rdy", 64'(RvviAxiRready), 64'(1));
        chk_rec("reset.rvvi");
`ifdef RVVI_DEPACK_STATS_EN
        chk("reset.good_cnt", 64'(GoodFrames), 64'(0));
        chk("reset.bad_cnt", 64'(BadFrames), 64'(0));
`endif

        build_frame(TB_DST, 16'h005c, 79, -1, 0);       run_frame("good1", -1, 2);
        build_frame(TB_DST, 16'h0800, 79, -1, 0);       run_frame("etype", -1, 0);
        build_frame(TB_DST, 16'h005c, 79, -1, 0);       run_frame("good2", -1, 1);
        build_frame(TB_DST, 16'h005c, 46, -1, 0);       run_frame("runt", -1, 0);
        build_frame(TB_DST, 16'h005c, 79, -1, 0);       run_frame("hold50", -1, 50);
        build_frame(TB_DST, 16'h005c, 79, -1, 0);
        frm[40] = 8'h00;                                 // tail's first word must miss the MAC
        run_frame("rst_mid", 9, 0);
        build_frame(TB_DST, 16'h005c, 79, -1, 0);       run_frame("good3", -1, 1);
        build_frame(TB_DST, 16'h005c, 79, 7, 0);        run_frame("tkeep", -1, 0);
        build_frame(TB_DST ^ 48'h0100_0000_0000, 16'h005c, 79, -1, 2);
        run_frame("mac_last", -1, 0);
        build_frame(TB_DST, 16'h005c, 79, -1, 3);       run_frame("hdr_runt", -1, 0);
        build_frame(TB_DST, 16'h005c, 119, -1, 0);      run_frame("padded", -1, 1);

        for (int i = 0; i < 16; i++) begin
            d  = TB_DST;
            et = 16'h005c;
            np = 79 + $urandom_range(0, 8);
            kb = -1;
            case ($urandom_range(0, 4))
                1:       d  = TB_DST ^ (48'd1 << $urandom_range(0, 47));
                2:       et = 16'($urandom);
                3:       np = $urandom_range(0, 78);
                4:       kb = $urandom_range(0, 22);
                default: ;
            endcase
            build_frame(d, et, np, kb, 0);
            run_frame($sformatf("rnd%0d", i), -1, $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
